// File: rtl/cam_capture_fsm_pkg.sv
// Shared definitions for the camera capture engine: FSM states, pixel
// format codes and standard frame sizes.
package cam_capture_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_ACTIVE  = 2'd2,
    S_HOLD    = 2'd3
  } cap_state_e;

  localparam logic FMT_RGB444 = 1'b0;
  localparam logic FMT_RGB565 = 1'b1;

  localparam int unsigned QQVGA_W = 160;
  localparam int unsigned QQVGA_H = 120;
  localparam int unsigned QVGA_W  = 320;
  localparam int unsigned QVGA_H  = 240;

endpackage

// File: rtl/cam_px_convert.sv
// Combinational pixel reducer: two camera bytes plus format -> DW-bit {R,G,B}.
// Ports: byte0/byte1 first/second byte of the pixel, fmt (0 RGB444, 1 RGB565),
//        px_c reduced pixel, DW/3 MSBs per channel.
module cam_px_convert
  import cam_capture_fsm_pkg::*;
#(
  parameter int unsigned DW = 3
) (
  input  logic [7:0]    byte0,
  input  logic [7:0]    byte1,
  input  logic          fmt,
  output logic [DW-1:0] px_c
);

  localparam int unsigned CW = DW / 3;

  // Channels left-aligned in 8 bits so truncation and zero-padding are one slice.
  logic [7:0] r_al;
  logic [7:0] g_al;
  logic [7:0] b_al;
  logic       unused_lsbs;

  always_comb begin
    r_al = 8'h00;
    g_al = 8'h00;
    b_al = 8'h00;
    if (fmt == FMT_RGB565) begin
      r_al = {byte0[7:3], 3'b000};
      g_al = {byte0[2:0], byte1[7:5], 2'b00};
      b_al = {byte1[4:0], 3'b000};
    end else begin
      r_al = {byte0[3:0], 4'h0};
      g_al = {byte1[7:4], 4'h0};
      b_al = {byte1[3:0], 4'h0};
    end
  end

  assign px_c = DW'({r_al[7 -: CW], g_al[7 -: CW], b_al[7 -: CW]});

  assign unused_lsbs = ^{r_al[7-CW:0], g_al[7-CW:0], b_al[7-CW:0]};

endmodule

// File: rtl/cam_capture_fsm.sv
// Camera pixel-capture engine: samples the 8-bit camera bus framed by
// VSYNC/HREF, assembles two-byte pixels, reduces them to DW bits and writes
// them to a frame buffer at row*IMG_W+col.
// Ports: PCLK clock, rst async active-low reset, D/VSYNC/HREF camera bus,
//        fmt pixel format, cap_en capture enable, oneshot single-frame mode,
//        mem_px_addr/mem_px_data/px_wr frame-buffer write port,
//        frame_done end-of-frame pulse, busy capturing, err_geom sticky
//        geometry error of the last frame.
module cam_capture_fsm
  import cam_capture_fsm_pkg::*;
#(
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 3,
  parameter int unsigned IMG_W = QQVGA_W,
  parameter int unsigned IMG_H = QQVGA_H
) (
  input  logic          PCLK,
  input  logic          rst,
  input  logic [7:0]    D,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic          fmt,
  input  logic          cap_en,
  input  logic          oneshot,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          busy,
  output logic          err_geom
);

  localparam int unsigned COL_W    = $clog2(IMG_W + 1);
  localparam int unsigned ROW_W    = $clog2(IMG_H + 1);
  localparam int unsigned BASE_W   = AW + 1;
  localparam int unsigned FRAME_PX = IMG_W * IMG_H;

  cap_state_e state_q;
  cap_state_e state_d;

  logic [7:0]        d_q;
  logic              vs_q;
  logic              href_q;
  logic              vs_p;
  logic              href_p;
  logic [7:0]        byte0_q;
  logic              phase_q;
  logic [COL_W-1:0]  col_q;
  logic              col_over_q;
  logic [ROW_W-1:0]  row_q;
  logic              row_over_q;
  logic [BASE_W-1:0] line_base_q;
  logic              line_err_q;

  logic              vs_rise_c;
  logic              vs_fall_c;
  logic              href_rise_c;
  logic              href_fall_c;
  logic              byte_ok_c;
  logic              eff_phase_c;
  logic              capture_c;
  logic              pix_c;
  logic              in_range_c;
  logic              frame_end_c;
  logic [BASE_W-1:0] px_addr_c;
  logic [DW-1:0]     px_c;

  // Edge detection on the registered bus; HREF activity during VSYNC is ignored.
  assign vs_rise_c   = vs_q & ~vs_p;
  assign vs_fall_c   = ~vs_q & vs_p;
  assign href_rise_c = href_q & ~href_p & ~vs_q;
  assign href_fall_c = ~href_q & href_p & ~vs_q;
  assign byte_ok_c   = href_q & ~vs_q;
  // A line always starts on byte0, whatever the previous line left behind.
  assign eff_phase_c = href_rise_c ? 1'b0 : phase_q;
  assign capture_c   = (state_q == S_ACTIVE) & cap_en;
  assign pix_c       = capture_c & byte_ok_c & eff_phase_c;
  assign px_addr_c   = line_base_q + BASE_W'(col_q);
  assign in_range_c  = (col_q < COL_W'(IMG_W)) && (row_q < ROW_W'(IMG_H)) &&
                       (px_addr_c < BASE_W'(FRAME_PX));

  cam_px_convert #(.DW(DW)) u_conv (
    .byte0 (byte0_q),
    .byte1 (d_q),
    .fmt   (fmt),
    .px_c  (px_c)
  );

  // State register.
  always_ff @(posedge PCLK or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; dropping cap_en aborts from any state without a frame end.
  always_comb begin
    state_d     = state_q;
    frame_end_c = 1'b0;
    case (state_q)
      S_IDLE:    if (cap_en) state_d = S_WAIT_VS;
      S_WAIT_VS: if (vs_fall_c) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (vs_rise_c) begin
          frame_end_c = 1'b1;
          state_d     = oneshot ? S_HOLD : S_WAIT_VS;
        end
      end
      S_HOLD:    state_d = S_HOLD;
      default:   state_d = S_IDLE;
    endcase
    if (!cap_en) begin
      state_d     = S_IDLE;
      frame_end_c = 1'b0;
    end
  end

  // Input sampling, byte phase, geometry counters and the write port.
  always_ff @(posedge PCLK or negedge rst) begin
    if (!rst) begin
      d_q         <= 8'h00;
      vs_q        <= 1'b0;
      href_q      <= 1'b0;
      vs_p        <= 1'b0;
      href_p      <= 1'b0;
      byte0_q     <= 8'h00;
      phase_q     <= 1'b0;
      col_q       <= '0;
      col_over_q  <= 1'b0;
      row_q       <= '0;
      row_over_q  <= 1'b0;
      line_base_q <= '0;
      line_err_q  <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      err_geom    <= 1'b0;
    end else begin
      d_q        <= D;
      vs_q       <= VSYNC;
      href_q     <= HREF;
      vs_p       <= vs_q;
      href_p     <= href_q;
      busy       <= (state_d == S_ACTIVE);
      px_wr      <= 1'b0;
      frame_done <= 1'b0;

      if (byte_ok_c) begin
        phase_q <= ~eff_phase_c;
        if (!eff_phase_c) byte0_q <= d_q;
      end

      if (frame_end_c) begin
        frame_done <= 1'b1;
        err_geom   <= line_err_q | row_over_q | (row_q != ROW_W'(IMG_H));
      end

      if (!capture_c || frame_end_c) begin
        col_q       <= '0;
        col_over_q  <= 1'b0;
        row_q       <= '0;
        row_over_q  <= 1'b0;
        line_base_q <= '0;
        line_err_q  <= 1'b0;
      end else begin
        if (pix_c) begin
          // col saturates at IMG_W; col_over remembers any pixel beyond it.
          if (col_q == COL_W'(IMG_W)) col_over_q <= 1'b1;
          else                        col_q      <= col_q + COL_W'(1);
          if (in_range_c) begin
            px_wr       <= 1'b1;
            mem_px_addr <= AW'(px_addr_c);
            mem_px_data <= px_c;
          end
        end
        if (href_fall_c) begin
          // A set phase here means a trailing byte0: odd byte count.
          if ((col_q != COL_W'(IMG_W)) || col_over_q || phase_q) line_err_q <= 1'b1;
          col_q      <= '0;
          col_over_q <= 1'b0;
          if (row_q == ROW_W'(IMG_H)) begin
            row_over_q <= 1'b1;
          end else begin
            row_q       <= row_q + ROW_W'(1);
            line_base_q <= line_base_q + BASE_W'(IMG_W);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_fsm.sv
// Bench for cam_capture_fsm: a default-size instance for the full QQVGA frame
// and a small 8x6, DW=12 instance for everything else.
module tb_cam_capture_fsm;

  localparam int SW = 8;
  localparam int SH = 6;

  logic PCLK = 1'b0;
  logic rst;
  logic [7:0] D;
  logic VSYNC, HREF, fmt, cap_en_d, cap_en_s, oneshot;

  logic [14:0] addr_d;
  logic [2:0]  data_d;
  logic        px_wr_d, fd_d, busy_d, err_d;
  logic [5:0]  addr_s;
  logic [11:0] data_s;
  logic        px_wr_s, fd_s, busy_s, err_s;

  always #5 PCLK = ~PCLK;

  cam_capture_fsm dut_d (
    .PCLK(PCLK), .rst(rst), .D(D), .VSYNC(VSYNC), .HREF(HREF), .fmt(fmt),
    .cap_en(cap_en_d), .oneshot(oneshot), .mem_px_addr(addr_d), .mem_px_data(data_d),
    .px_wr(px_wr_d), .frame_done(fd_d), .busy(busy_d), .err_geom(err_d));

  cam_capture_fsm #(.AW(6), .DW(12), .IMG_W(SW), .IMG_H(SH)) dut_s (
    .PCLK(PCLK), .rst(rst), .D(D), .VSYNC(VSYNC), .HREF(HREF), .fmt(fmt),
    .cap_en(cap_en_s), .oneshot(oneshot), .mem_px_addr(addr_s), .mem_px_data(data_s),
    .px_wr(px_wr_s), .frame_done(fd_s), .busy(busy_s), .err_geom(err_s));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitors.
  int d_cnt = 0, d_addr_bad = 0, d_data_bad = 0, fd_cnt_d = 0;
  int unsigned wa[$];
  logic [11:0] wd[$];
  int fd_cnt_s = 0, fd_wide = 0;
  logic fd_prev_s = 1'b0;

  always @(negedge PCLK) begin
    if (px_wr_d === 1'b1) begin
      if (int'(addr_d) != d_cnt) d_addr_bad++;
      if (data_d !== 3'b110) d_data_bad++;
      d_cnt++;
    end
    if (fd_d === 1'b1) fd_cnt_d++;
    if (px_wr_s === 1'b1) begin
      wa.push_back(32'(addr_s));
      wd.push_back(data_s);
    end
    if (fd_s === 1'b1) begin
      fd_cnt_s++;
      if (fd_prev_s) fd_wide++;
    end
    fd_prev_s = (fd_s === 1'b1);
  end

  // Frame description driven by send_frame.
  logic [7:0] fb [0:127][0:335];
  int ln_len [0:127];
  int ln_gap [0:127];
  int n_lines;
  int rst_base;

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic fill_const(input int nl, input int len, input logic [7:0] b0, input logic [7:0] b1);
    n_lines = nl;
    for (int l = 0; l < 128; l++) begin
      ln_len[l] = len;
      ln_gap[l] = 2;
      for (int j = 0; j < 336; j++) fb[l][j] = (j % 2 == 1) ? b1 : b0;
    end
  endtask

  task automatic fill_rand(input bit clean);
    int k;
    n_lines = SH;
    if (!clean) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) n_lines = SH - 1;
      if (k == 1) n_lines = SH + 1;
    end
    for (int l = 0; l < n_lines; l++) begin
      ln_len[l] = 2 * SW;
      ln_gap[l] = int'($urandom_range(1, 4));
      if (!clean) begin
        k = int'($urandom_range(0, 11));
        if (k == 0) ln_len[l] = 2 * SW - 1;
        if (k == 1) ln_len[l] = 2 * SW + 1;
        if (k == 2) ln_len[l] = 2 * SW + 2;
        if (k == 3) ln_len[l] = 2 * SW - 2;
      end
      for (int j = 0; j < ln_len[l]; j++) fb[l][j] = 8'($urandom_range(0, 255));
    end
  endtask

  // ev_kind 1: raise cap_en_s at start of line ev_line; 2: reset pulse inside it.
  task automatic send_frame(input int ev_line, input int ev_kind);
    VSYNC = 1'b1; HREF = 1'b0; D = 8'h00;
    repeat (4) cyc();
    VSYNC = 1'b0;
    repeat (3) cyc();
    for (int l = 0; l < n_lines; l++) begin
      if (ev_kind == 1 && l == ev_line) cap_en_s = 1'b1;
      for (int j = 0; j < ln_len[l]; j++) begin
        HREF = 1'b1;
        D    = fb[l][j];
        if (ev_kind == 2 && l == ev_line && j == 4) begin
          chk("rst-pre-busy", 64'(busy_s), 64'(1));
          rst = 1'b0;
          #2;
          chk("rst-px_wr", 64'(px_wr_s), 64'(0));
          chk("rst-busy", 64'(busy_s), 64'(0));
          chk("rst-addr", 64'(addr_s), 64'(0));
          chk("rst-data", 64'(data_s), 64'(0));
          chk("rst-fd-err", 64'({fd_s, err_s}), 64'(0));
          rst_base = wa.size();
        end
        if (ev_kind == 2 && l == ev_line && j == 7) rst = 1'b1;
        cyc();
      end
      HREF = 1'b0;
      D    = 8'h00;
      repeat (ln_gap[l]) cyc();
    end
    repeat (3) cyc();
    VSYNC = 1'b1;
    repeat (5) cyc();
  endtask

  // Reference pixel: each channel as an integer of width w, keep top 4 bits.
  function automatic logic [11:0] conv12(input logic f, input logic [7:0] b0, input logic [7:0] b1);
    int unsigned x0, x1, r, g, b, rw, gw, bw;
    x0 = 32'(b0);
    x1 = 32'(b1);
    if (f) begin
      r = x0 / 8; g = (x0 % 8) * 8 + x1 / 32; b = x1 % 32; rw = 5; gw = 6; bw = 5;
    end else begin
      r = x0 % 16; g = x1 / 16; b = x1 % 16; rw = 4; gw = 4; bw = 4;
    end
    return {4'((r * 16) >> rw), 4'((g * 16) >> gw), 4'((b * 16) >> bw)};
  endfunction

  int unsigned ea[$];
  logic [11:0] ed[$];
  logic exp_err;

  task automatic model_frame();
    ea.delete();
    ed.delete();
    exp_err = (n_lines != SH);
    for (int l = 0; l < n_lines; l++) begin
      if (ln_len[l] != 2 * SW) exp_err = 1'b1;
      for (int p = 0; p < ln_len[l] / 2; p++)
        if (p < SW && l < SH) begin
          ea.push_back(32'(l * SW + p));
          ed.push_back(conv12(fmt, fb[l][2*p], fb[l][2*p+1]));
        end
    end
  endtask

  task automatic cmp_writes(input string name, input int base);
    int n, m, k;
    n = wa.size() - base;
    chk({name, "-count"}, 64'(n), 64'(ea.size()));
    m = (n < ea.size()) ? n : ea.size();
    if (m > 0) begin
      k = m - 1;
      for (int i = 0; i < m; i++)
        if (wa[base+i] != ea[i] || wd[base+i] != ed[i]) begin k = i; break; end
      chk({name, "-px"}, {20'd0, wa[base+k], wd[base+k]}, {20'd0, ea[k], ed[k]});
    end
  endtask

  // One model-checked frame on the small instance.
  task automatic run_checked(input string name, input bit clean);
    int base, fdb;
    fill_rand(clean);
    model_frame();
    base = wa.size();
    fdb  = fd_cnt_s;
    send_frame(0, 0);
    cmp_writes(name, base);
    chk({name, "-fd"}, 64'(fd_cnt_s - fdb), 64'(1));
    chk({name, "-err"}, 64'(err_s), 64'(exp_err));
  endtask

  typedef struct {
    logic       f;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int base, fdb, k;
    vecs[0] = '{1'b1, 8'hF8, 8'h1F, 12'hF0F};
    vecs[1] = '{1'b0, 8'h0F, 8'hF0, 12'hFF0};
    vecs[2] = '{1'b0, 8'hA5, 8'h3C, 12'h53C};
    vecs[3] = '{1'b1, 8'h07, 8'hE0, 12'h0F0};
    vecs[4] = '{1'b1, 8'hFF, 8'hFF, 12'hFFF};
    vecs[5] = '{1'b0, 8'hF0, 8'h0F, 12'h00F};
    vecs[6] = '{1'b1, 8'hA5, 8'h5A, 12'hAAD};
    vecs[7] = '{1'b1, 8'h12, 8'h34, 12'h14A};

    rst = 1'b0; D = 8'h00; VSYNC = 1'b0; HREF = 1'b0; fmt = 1'b0;
    cap_en_d = 1'b0; cap_en_s = 1'b0; oneshot = 1'b0;
    repeat (3) cyc();
    chk("reset-px_wr", 64'({px_wr_s, px_wr_d}), 64'(0));
    chk("reset-fd", 64'({fd_s, fd_d}), 64'(0));
    chk("reset-busy", 64'({busy_s, busy_d}), 64'(0));
    chk("reset-err", 64'({err_s, err_d}), 64'(0));
    chk("reset-addr", 64'({addr_s, addr_d}), 64'(0));
    chk("reset-data", 64'({data_s, data_d}), 64'(0));
    rst = 1'b1;
    cyc();

    // Full QQVGA frame on the default instance.
    cap_en_d = 1'b1;
    fmt = 1'b0;
    fill_const(120, 320, 8'h0F, 8'hF0);
    send_frame(0, 0);
    chk("full-writes", 64'(d_cnt), 64'(19200));
    chk("full-addr-seq", 64'(d_addr_bad), 64'(0));
    chk("full-data", 64'(d_data_bad), 64'(0));
    chk("full-fd", 64'(fd_cnt_d), 64'(1));
    chk("full-err", 64'(err_d), 64'(0));
    cap_en_d = 1'b0;

    // Format table, one clean frame per vector.
    cap_en_s = 1'b1;
    for (int v = 0; v < 8; v++) begin
      fmt = vecs[v].f;
      fill_const(SH, 2 * SW, vecs[v].b0, vecs[v].b1);
      base = wa.size();
      send_frame(0, 0);
      chk($sformatf("vec%0d-count", v), 64'(wa.size() - base), 64'(SW * SH));
      if (wa.size() > base) begin
        k = wa.size() - 1;
        for (int i = base; i < wa.size(); i++)
          if (wd[i] != vecs[v].exp) begin k = i; break; end
        chk($sformatf("vec%0d-data", v), 64'(wd[k]), 64'(vecs[v].exp));
      end
    end
    chk("vec-err", 64'(err_s), 64'(0));

    // Write latency: byte1 on D, px_wr two cycles later.
    fdb = fd_cnt_s;
    VSYNC = 1'b1; repeat (4) cyc();
    VSYNC = 1'b0; repeat (3) cyc();
    fmt = 1'b1; HREF = 1'b1; D = 8'hF8; cyc();
    D = 8'h1F; cyc();
    HREF = 1'b0; D = 8'h00;
    @(negedge PCLK); chk("lat-early", 64'(px_wr_s), 64'(0));
    @(negedge PCLK); chk("lat-on", 64'(px_wr_s), 64'(1));
    chk("lat-word", 64'({addr_s, data_s}), 64'({6'd0, 12'hF0F}));
    @(negedge PCLK); chk("lat-width", 64'(px_wr_s), 64'(0));
    cyc(); repeat (3) cyc();
    VSYNC = 1'b1; repeat (5) cyc();
    chk("lat-fd", 64'(fd_cnt_s - fdb), 64'(1));
    chk("lat-err", 64'(err_s), 64'(1));
    run_checked("clean-a", 1'b1);

    // Long line and short frame, then recovery.
    fill_rand(1'b1);
    n_lines = SH - 1;
    ln_len[2] = 2 * SW + 2;
    for (int j = 0; j < 2 * SW + 2; j++) fb[2][j] = 8'($urandom_range(0, 255));
    model_frame();
    base = wa.size();
    send_frame(0, 0);
    cmp_writes("geom", base);
    chk("geom-err", 64'(err_s), 64'(1));
    run_checked("geom-recover", 1'b1);

    // cap_en raised mid-frame: nothing until the next frame start.
    cap_en_s = 1'b0;
    repeat (2) cyc();
    fill_rand(1'b1);
    base = wa.size();
    fdb  = fd_cnt_s;
    send_frame(2, 1);
    chk("late-en-writes", 64'(wa.size() - base), 64'(0));
    chk("late-en-fd", 64'(fd_cnt_s - fdb), 64'(0));
    run_checked("late-en-next", 1'b1);

    // Reset in the middle of a line.
    fill_rand(1'b1);
    fdb = fd_cnt_s;
    send_frame(3, 2);
    chk("rst-no-writes", 64'(wa.size() - rst_base), 64'(0));
    chk("rst-no-fd", 64'(fd_cnt_s - fdb), 64'(0));
    run_checked("rst-next", 1'b1);

    // One-shot across three frames, then re-arm.
    oneshot = 1'b1;
    fill_rand(1'b1);
    model_frame();
    base = wa.size();
    fdb  = fd_cnt_s;
    repeat (3) send_frame(0, 0);
    cmp_writes("oneshot", base);
    chk("oneshot-fd", 64'(fd_cnt_s - fdb), 64'(1));
    chk("oneshot-busy", 64'(busy_s), 64'(0));
    cap_en_s = 1'b0; repeat (2) cyc();
    cap_en_s = 1'b1;
    run_checked("oneshot-rearm", 1'b1);
    oneshot = 1'b0;
    cap_en_s = 1'b0; repeat (2) cyc();
    cap_en_s = 1'b1;

    // Random geometry and data against the model.
    for (int f = 0; f < 12; f++) begin
      fmt = 1'($urandom_range(0, 1));
      run_checked($sformatf("rand%0d", f), 1'b0);
    end

    chk("fd-one-cycle", 64'(fd_wide), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_capture_fsm.md
Name: cam_capture_fsm

Overview:
- Parametrised camera pixel-capture engine, successor to the fixed QQVGA/RGB111 capture FSM.
- Samples the 8-bit camera bus on PCLK, framed by VSYNC/HREF, and assembles two-byte pixels in RGB444 or RGB565.
- Reduces each pixel to DW bits (DW/3 MSBs per channel) and writes it to the frame buffer at row*IMG_W+col.
- Adds frame-start synchronisation, per-line byte-phase realignment, size clipping, geometry error flags, one-shot mode and a frame-done strobe.

Parameters:
- AW, 15, frame-buffer address width; must satisfy 2^AW >= IMG_W*IMG_H.
- DW, 3, stored pixel width; must be 3, 6, 9 or 12. Each channel keeps DW/3 bits.
- IMG_W, 160, pixels per line.
- IMG_H, 120, lines per frame.

Ports:
- PCLK  in  1  camera pixel clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- D  in  8  camera data bus.
- VSYNC  in  1  high = vertical blanking.
- HREF  in  1  high = valid line bytes.
- fmt  in  1  0 = RGB444 (byte0 xxxxRRRR, byte1 GGGGBBBB); 1 = RGB565 (byte0 RRRRRGGG, byte1 GGGBBBBB).
- cap_en  in  1  capture enable.
- oneshot  in  1  1 = capture a single frame per cap_en assertion.
- mem_px_addr  out  AW  write address.
- mem_px_data  out  DW  write data, packed {R,G,B}.
- px_wr  out  1  write strobe, one cycle per pixel.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- busy  out  1  high while in S_ACTIVE.
- err_geom  out  1  sticky flag: the last frame had a wrong line length or line count.

Behaviour:
- Reset: all outputs 0, state S_IDLE, counters 0, byte phase 0, stored VSYNC/HREF samples 0.
- Inputs D, VSYNC and HREF are registered once. All decisions use the registered copies plus one previous sample for edge detection.
- State machine:
  - S_IDLE: go to S_WAIT_VS when cap_en = 1.
  - S_WAIT_VS: wait for a VSYNC falling edge, then go to S_ACTIVE. A frame already in progress is never captured partially.
  - S_ACTIVE: capture pixels. On a VSYNC rising edge, go to S_WAIT_VS (continuous) or S_HOLD (oneshot = 1).
  - S_HOLD: go to S_IDLE when cap_en = 0.
  - From any state, cap_en = 0 returns the FSM to S_IDLE on the next cycle. An in-flight pixel is dropped, and frame_done and err_geom are not updated.
- Byte phase:
  - Cleared on every HREF rising edge, so byte0 is always the first byte of a line.
  - Toggles on each byte accepted with HREF = 1.
- Pixel assembly:
  - byte0 is latched.
  - On byte1, channels are extracted per fmt: RGB444 gives 4-bit channels; RGB565 gives 5/6/5-bit channels.
  - Each channel is truncated to its DW/3 MSBs. If DW/3 exceeds the channel width, the channel is left-aligned and zero-padded.
- Write timing:
  - px_wr rises in the cycle after the registered byte1, with mem_px_addr and mem_px_data valid in that same cycle.
  - Total latency from byte1 on D to px_wr is 2 PCLK cycles.
- Addressing:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1. The address is maintained incrementally; no multiplier is used.
  - The first pixel of a frame is written to address 0.
  - Pixels with col >= IMG_W are not written (px_wr stays 0).
  - Lines with row >= IMG_H are not written.
  - col resets and row increments on each HREF falling edge.
- Frame end (VSYNC rising edge in S_ACTIVE):
  - frame_done pulses for exactly 1 cycle.
  - err_geom = 1 if any line had a pixel count != IMG_W, or if the line count != IMG_H. Otherwise err_geom = 0.
  - err_geom holds its value until the next frame end.
  - Counters clear.
- Odd byte count in a line: the trailing byte0 is discarded at the HREF falling edge and the line is flagged as a length error.
- HREF = 1 while VSYNC = 1: ignored.
- The address never wraps; any address that would reach or exceed IMG_W*IMG_H is suppressed.

Decomposition:
- Shared package/header holds:
  - state encodings S_IDLE, S_WAIT_VS, S_ACTIVE, S_HOLD;
  - fmt codes FMT_RGB444 = 0 and FMT_RGB565 = 1;
  - QQVGA/QVGA size constants.
- One sub-module, cam_px_convert: combinational byte0/byte1 + fmt -> DW-bit pixel, parametrised by DW. It is unit-testable in isolation.

Test Plan:
- Reset mid-line (rst low for 3 cycles during S_ACTIVE) -> all outputs 0 immediately; the next capture waits for a fresh VSYNC falling edge.
- Defaults (DW=3, IMG_W=160, IMG_H=120), fmt = 0, continuous, one clean frame of bytes 0x0F,0xF0 -> 19200 writes, addresses 0..19199, data 3'b110; single frame_done pulse; err_geom = 0.
- DW=12, fmt = 1, pixel bytes 0xF8,0x1F -> mem_px_data = 12'hF0F, written 2 cycles after byte1.
- cap_en raised mid-frame -> zero writes until the next VSYNC falling edge; the following frame starts at address 0.
- One line with 161 pixels and a frame with 119 lines -> the 161st pixel is not written; err_geom = 1 after frame_done. The next clean frame clears err_geom.
- oneshot = 1, cap_en held high across 3 frames -> exactly one frame captured, FSM parks in S_HOLD; dropping then raising cap_en captures one more frame.
